gsensor_avg: RTL and testbench
==============================

# gsensor_avg

Sliding-window boxcar averager sitting directly downstream of `gsensor`. It takes each `data_valid`-qualified X/Y/Z accelerometer sample, keeps the last 2^LOG2_DEPTH samples per axis in a circular buffer and maintains a running sum. It emits one averaged X/Y/Z triple per accepted sample once the window is full. Its output feeds display and tilt logic that needs noise-reduced readings.

## Interface

Parameters:
- `WIDTH`, 16: sample width, signed two's complement; matches the `gsensor` outputs.
- `LOG2_DEPTH`, 3: log2 of window depth (DEPTH = 8). Legal range 1..6.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `data_valid`  in  1  one-cycle qualifier for `data_x/y/z`; may be high on consecutive cycles.
- `data_x`, `data_y`, `data_z`  in  WIDTH each  signed samples, valid only when `data_valid` is high.
- `clear`  in  1  synchronous flush of window, sums and count.
- `avg_valid`  out  1  one-cycle pulse; `avg_x/y/z` are updated on this cycle.
- `avg_x`, `avg_y`, `avg_z`  out  WIDTH each  signed window averages; held between pulses.
- `primed`  out  1  high once DEPTH samples have been accepted since the last reset or clear.

## Operation

- Storage: per axis, DEPTH × WIDTH register buffer, shared write pointer `wr_ptr` (LOG2_DEPTH bits), sum register of WIDTH+LOG2_DEPTH bits (signed), fill counter 0..DEPTH (saturating).
- Accept (stage 1), in a cycle with `data_valid`=1 and `clear`=0:
  - `sum <= sum + sample − buf[wr_ptr]`, computed with sign extension.
  - `buf[wr_ptr] <= sample`.
  - `wr_ptr <= wr_ptr + 1`, wrapping DEPTH−1 → 0.
  - The counter increments, saturating at DEPTH.
  - The buffer is zero after reset/clear, so the sum is exact during fill.
- Output (stage 2):
  - Stage-1 valid flag `s1_valid` is registered as `data_valid & (count_next == DEPTH)`.
  - When `s1_valid`=1: `avg_* <= sum >>> LOG2_DEPTH`, using an arithmetic shift (floor toward −∞), truncated to WIDTH. Truncation is lossless because |sum| ≤ DEPTH·2^(WIDTH−1). Then `avg_valid <= 1`; otherwise `avg_valid <= 0`.
- `primed` equals `count == DEPTH`, and is registered.
- No averages are produced while filling: the first `avg_valid` follows the DEPTH-th accepted sample.
- `clear`:
  - Next edge: zeroes buffers, sums, `wr_ptr`, count, `primed` and `s1_valid`.
  - Takes priority over a simultaneous `data_valid`; that sample is dropped.
  - `avg_*` are held; an `avg_valid` already scheduled for the next cycle is cancelled.
- No back-pressure: every `data_valid` is accepted, and sustained one-sample-per-cycle input is supported.

## Timing

- Reset values, applied asynchronously: `avg_valid`=0, `avg_x/y/z`=0, `primed`=0, all buffers, sums, pointer, counter and `s1_valid` = 0.
- Latency: `data_valid` high in cycle N → `avg_valid` high in cycle N+2, with `avg_*` valid in that same cycle.
- `primed` rises in cycle N+1 after the DEPTH-th accepted sample (cycle N), one cycle before the first `avg_valid`.
- Back-to-back `data_valid` in cycles N, N+1 → `avg_valid` in N+2, N+3, each reflecting its own window.
- Reset asserted mid-operation: all state clears immediately; no `avg_valid` is emitted for samples in flight. After deassertion, the block refills from empty.
- `clear` in cycle N: the state is empty in cycle N+1. `avg_valid` is 0 in N+1 even if `data_valid` was high in N−1.

## Test plan

- Reset/idle: hold `reset` for 10 cycles, then release with no input → all outputs 0, `primed`=0, `avg_valid` never pulses.
- Priming: apply 8 samples (x=100, y=−200, z=1000), spaced 5 cycles apart → no `avg_valid` for samples 1–7. `primed` rises 1 cycle after sample 8. `avg_valid` pulses 2 cycles after sample 8 with avg = (100, −200, 1000).
- Sliding/wrap: after priming, send sample 9 with x=900 (y, z unchanged) → avg_x=200. Send 8 more samples of x=900 → avg_x=900 on the last one; `wr_ptr` has wrapped twice.
- Extremes and rounding:
  - 8× x=0x7FFF → avg_x=0x7FFF.
  - 8× x=0x8000 → avg_x=0x8000.
  - Alternating x=−1,0 ×4 → sum −4 → avg_x=−1.
- Back-to-back: send 12 samples on consecutive cycles, x=1..12 → `avg_valid` on 5 consecutive cycles with avg_x = 4, 5, 6, 7, 8 (floor of 4.5, 5.5, …).
- Clear and reset mid-stream:
  - After priming, assert `clear` in the same cycle as `data_valid` → sample dropped, `primed`=0, no `avg_valid`, `avg_*` held, and 8 new samples are needed again.
  - Repeat the scenario with async `reset` asserted between clock edges → outputs zero immediately.

Source files
------------

// File: rtl/gsensor_avg_if.sv
// Sample-in / average-out bundle between gsensor, the boxcar averager and its consumers.
interface gsensor_avg_if #(
  parameter int WIDTH = 16
);
  logic                    data_valid;
  logic signed [WIDTH-1:0] data_x;
  logic signed [WIDTH-1:0] data_y;
  logic signed [WIDTH-1:0] data_z;
  logic                    clear;
  logic                    avg_valid;
  logic signed [WIDTH-1:0] avg_x;
  logic signed [WIDTH-1:0] avg_y;
  logic signed [WIDTH-1:0] avg_z;
  logic                    primed;

  modport master (
    output data_valid, data_x, data_y, data_z, clear,
    input  avg_valid, avg_x, avg_y, avg_z, primed
  );

  modport slave (
    input  data_valid, data_x, data_y, data_z, clear,
    output avg_valid, avg_x, avg_y, avg_z, primed
  );
endinterface

// File: rtl/gsensor_avg.sv
// Sliding-window boxcar averager for X/Y/Z accelerometer samples: circular buffer plus
// running sum per axis, one averaged triple per accepted sample once the window is full.
module gsensor_avg #(
  parameter int WIDTH      = 16,
  parameter int LOG2_DEPTH = 3
) (
  input logic         clk,
  input logic         reset,
  gsensor_avg_if.slave bus
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = WIDTH + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0]   FULL    = (LOG2_DEPTH + 1)'(DEPTH);
  localparam logic [LOG2_DEPTH:0]   CNT_ONE = (LOG2_DEPTH + 1)'(1);
  localparam logic [LOG2_DEPTH-1:0] PTR_ONE = (LOG2_DEPTH)'(1);

  function automatic logic signed [SW-1:0] sext(input logic signed [WIDTH-1:0] v);
    return SW'(v);
  endfunction

  logic signed [WIDTH-1:0] buf_q [3][DEPTH];
  logic signed [SW-1:0]    sum_q [3];
  logic signed [SW-1:0]    sum_d [3];
  logic signed [WIDTH-1:0] avg_q [3];
  logic signed [WIDTH-1:0] avg_d [3];
  logic signed [WIDTH-1:0] sample_s [3];
  logic [LOG2_DEPTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH:0]     count_q, count_d;
  logic                    s1_valid_q;
  logic                    avg_valid_q;
  logic                    primed_q;

  // Next-state arithmetic: the oldest sample leaves the sum as the new one enters.
  always_comb begin
    sample_s[0] = bus.data_x;
    sample_s[1] = bus.data_y;
    sample_s[2] = bus.data_z;
    wr_ptr_d    = wr_ptr_q + PTR_ONE;
    if (count_q == FULL) begin
      count_d = count_q;
    end else begin
      count_d = count_q + CNT_ONE;
    end
    for (int a = 0; a < 3; a++) begin
      sum_d[a] = sum_q[a] + sext(sample_s[a]) - sext(buf_q[a][wr_ptr_q]);
      avg_d[a] = WIDTH'(sum_q[a] >>> LOG2_DEPTH);
    end
  end

  // Window state (stage 1) and averaged outputs (stage 2); clear outranks a new sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < 3; a++) begin
        for (int i = 0; i < DEPTH; i++) begin
          buf_q[a][i] <= '0;
        end
        sum_q[a] <= '0;
        avg_q[a] <= '0;
      end
      wr_ptr_q    <= '0;
      count_q     <= '0;
      primed_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      avg_valid_q <= 1'b0;
    end else if (bus.clear) begin
      for (int a = 0; a < 3; a++) begin
        for (int i = 0; i < DEPTH; i++) begin
          buf_q[a][i] <= '0;
        end
        sum_q[a] <= '0;
      end
      wr_ptr_q    <= '0;
      count_q     <= '0;
      primed_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      avg_valid_q <= 1'b0;
    end else begin
      if (bus.data_valid) begin
        for (int a = 0; a < 3; a++) begin
          buf_q[a][wr_ptr_q] <= sample_s[a];
          sum_q[a]           <= sum_d[a];
        end
        wr_ptr_q   <= wr_ptr_d;
        count_q    <= count_d;
        primed_q   <= (count_d == FULL);
        s1_valid_q <= (count_d == FULL);
      end else begin
        s1_valid_q <= 1'b0;
      end
      if (s1_valid_q) begin
        for (int a = 0; a < 3; a++) begin
          avg_q[a] <= avg_d[a];
        end
        avg_valid_q <= 1'b1;
      end else begin
        avg_valid_q <= 1'b0;
      end
    end
  end

  assign bus.avg_valid = avg_valid_q;
  assign bus.avg_x     = avg_q[0];
  assign bus.avg_y     = avg_q[1];
  assign bus.avg_z     = avg_q[2];
  assign bus.primed    = primed_q;
endmodule

// File: tb/tb_gsensor_avg.sv
// Directed bench for gsensor_avg: priming, sliding window, extremes, back-to-back, clear, reset.
module tb_gsensor_avg;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  gsensor_avg_if #(.WIDTH(16)) bus ();

  gsensor_avg #(.WIDTH(16), .LOG2_DEPTH(3)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_avg(input string tag, input int ex, input int ey, input int ez);
    chk({tag, ".x"}, int'(bus.avg_x), ex);
    chk({tag, ".y"}, int'(bus.avg_y), ey);
    chk({tag, ".z"}, int'(bus.avg_z), ez);
  endtask

  // One sample followed by four idle cycles, checking primed, latency and result.
  task automatic ssend(input string tag, input int x, input int y, input int z,
                       input int exp_primed, input int exp_v,
                       input int ex, input int ey, input int ez);
    bus.data_valid = 1'b1;
    bus.data_x = 16'(x);
    bus.data_y = 16'(y);
    bus.data_z = 16'(z);
    step();
    bus.data_valid = 1'b0;
    chk({tag, ".primed"}, int'(bus.primed), exp_primed);
    chk({tag, ".v_n1"}, int'(bus.avg_valid), 0);
    step();
    chk({tag, ".v_n2"}, int'(bus.avg_valid), exp_v);
    if (exp_v != 0) chk_avg(tag, ex, ey, ez);
    repeat (3) begin
      step();
      chk({tag, ".v_idle"}, int'(bus.avg_valid), 0);
    end
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("clear.primed", int'(bus.primed), 0);
    chk("clear.valid", int'(bus.avg_valid), 0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    bus.data_valid = 1'b0;
    bus.data_x = 16'sd0;
    bus.data_y = 16'sd0;
    bus.data_z = 16'sd0;
    bus.clear = 1'b0;

    // Reset / idle
    repeat (10) step();
    chk("rst.valid", int'(bus.avg_valid), 0);
    chk("rst.primed", int'(bus.primed), 0);
    chk_avg("rst", 0, 0, 0);
    #2 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle.valid", int'(bus.avg_valid), 0);
      chk("idle.primed", int'(bus.primed), 0);
    end
    chk_avg("idle", 0, 0, 0);

    // Priming
    for (int i = 1; i <= 7; i++) ssend("prime", 100, -200, 1000, 0, 0, 0, 0, 0);
    ssend("prime8", 100, -200, 1000, 1, 1, 100, -200, 1000);

    // Sliding window and pointer wrap
    ssend("slide9", 900, -200, 1000, 1, 1, 200, -200, 1000);
    for (int k = 1; k <= 8; k++)
      ssend("slide", 900, -200, 1000, 1, 1, (k >= 7) ? 900 : 200 + 100 * k, -200, 1000);

    // Extremes and floor rounding
    do_clear();
    for (int i = 1; i <= 7; i++) ssend("max", 32767, -200, 1000, 0, 0, 0, 0, 0);
    ssend("max8", 32767, -200, 1000, 1, 1, 32767, -200, 1000);
    do_clear();
    for (int i = 1; i <= 7; i++) ssend("min", -32768, -200, 1000, 0, 0, 0, 0, 0);
    ssend("min8", -32768, -200, 1000, 1, 1, -32768, -200, 1000);
    do_clear();
    for (int i = 1; i <= 7; i++) ssend("alt", (i % 2 == 1) ? -1 : 0, -200, 1000, 0, 0, 0, 0, 0);
    ssend("alt8", 0, -200, 1000, 1, 1, -1, -200, 1000);

    // Back-to-back samples x = 1..12
    do_clear();
    for (int c = 0; c < 14; c++) begin
      if (c < 12) begin
        bus.data_valid = 1'b1;
        bus.data_x = 16'(c + 1);
      end else begin
        bus.data_valid = 1'b0;
      end
      step();
      chk("b2b.valid", int'(bus.avg_valid), (c >= 8 && c <= 12) ? 1 : 0);
      if (c >= 8 && c <= 12) chk_avg("b2b", c - 4, -200, 1000);
    end
    bus.data_valid = 1'b0;

    // Clear with a pending average and a simultaneous sample
    bus.data_valid = 1'b1;
    bus.data_x = 16'sd16;
    step();
    chk("clr.pend", int'(bus.avg_valid), 0);
    bus.clear = 1'b1;
    bus.data_x = 16'sd5000;
    step();
    bus.clear = 1'b0;
    bus.data_valid = 1'b0;
    chk("clr.cancel", int'(bus.avg_valid), 0);
    chk("clr.primed", int'(bus.primed), 0);
    chk("clr.hold_x", int'(bus.avg_x), 8);
    step();
    chk("clr.valid2", int'(bus.avg_valid), 0);
    chk_avg("clr.hold", 8, -200, 1000);
    for (int i = 1; i <= 7; i++) ssend("refill", 40, -200, 1000, 0, 0, 0, 0, 0);
    ssend("refill8", 40, -200, 1000, 1, 1, 40, -200, 1000);

    // Asynchronous reset with a sample in flight
    bus.data_valid = 1'b1;
    bus.data_x = 16'sd77;
    @(posedge clk);
    #3 reset = 1'b1;
    bus.data_valid = 1'b0;
    #1;
    chk("arst.valid", int'(bus.avg_valid), 0);
    chk("arst.primed", int'(bus.primed), 0);
    chk_avg("arst", 0, 0, 0);
    step();
    chk("arst.inflight", int'(bus.avg_valid), 0);
    #2 reset = 1'b0;
    step();
    for (int i = 1; i <= 7; i++) ssend("rfill", -8, 3, -5, 0, 0, 0, 0, 0);
    ssend("rfill8", -8, 3, -5, 1, 1, -8, 3, -5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
